// File: rtl/fisr_pkg.sv
// Shared types and constants for the fast inverse square root front end:
// float field positions, special values, operand classes and helpers.
package fisr_pkg;

   localparam logic [31:0] FISR_MAGIC = 32'h5F3759DF;

   localparam int SIGN_B = 31;
   localparam int EXP_HI = 30;
   localparam int EXP_LO = 23;
   localparam int MAN_HI = 22;
   localparam int MAN_LO = 0;

   localparam logic [7:0]  EXP_MAX    = 8'hFF;
   localparam logic [31:0] FP_POS_INF = 32'h7F800000;
   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [31:0] FP_ZERO    = 32'h00000000;

   typedef enum logic [2:0] {
      NORM,
      ZERO,
      DENORM,
      INF,
      NAN
   } fp_class_t;

   typedef struct packed {
      logic        hit;
      logic [31:0] val;
   } fp_special_t;

   // x/2 by exponent decrement; tiny inputs flush to signed zero, Inf/NaN pass through.
   function automatic logic [31:0] fp_half(input logic [31:0] x);
      logic [7:0] e;
      e = x[EXP_HI:EXP_LO];
      if (e == EXP_MAX)
         return x;
      else if (e < 8'd2)
         return {x[SIGN_B], 31'h0};
      else
         return {x[SIGN_B], e - 8'd1, x[MAN_HI:MAN_LO]};
   endfunction

   // Final 1/sqrt(x) for inputs the Newton-Raphson path cannot handle.
   function automatic fp_special_t special_of(input fp_class_t cls, input logic sign);
      fp_special_t s;
      s = '{hit: 1'b1, val: FP_ZERO};
      case (cls)
         ZERO, DENORM: s.val = FP_POS_INF;
         NAN:          s.val = FP_QNAN;
         INF:          s.val = sign ? FP_QNAN : FP_ZERO;
         default:      s = sign ? '{hit: 1'b1, val: FP_QNAN} : '{hit: 1'b0, val: FP_ZERO};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/fisr_classify.sv
// Combinational IEEE-754 single classifier: returns operand class and sign.
module fisr_classify
   import fisr_pkg::*;
(
   input  logic [31:0] x,
   output fp_class_t   cls,
   output logic        sign
);

   logic [7:0]  exp_f;
   logic [22:0] man_f;

   assign exp_f = x[EXP_HI:EXP_LO];
   assign man_f = x[MAN_HI:MAN_LO];
   assign sign  = x[SIGN_B];

   always_comb begin
      cls = NORM;
      if (exp_f == 8'h00)
         cls = (man_f == '0) ? ZERO : DENORM;
      else if (exp_f == EXP_MAX)
         cls = (man_f == '0) ? INF : NAN;
   end

endmodule

// File: rtl/fisr_seed_gen.sv
// Two-stage seed generator for fast 1/sqrt: y0 = MAGIC - (x >> 1) and x/2, valid/ready.
// Define FISR_SPECIAL_CASE_EN to add the special-input classifier and bypass value.
module fisr_seed_gen
   import fisr_pkg::*;
#(
   parameter logic [31:0] MAGIC = FISR_MAGIC,
   parameter int          TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_seed,
   output logic [31:0]      out_x_half,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_special,
   output logic [31:0]      out_special_val
);

   logic             adv1, adv2;

   logic             s1_valid;
   logic [31:0]      s1_x;
   logic [TAG_W-1:0] s1_tag;
   fp_special_t      s1_special;

   logic             s2_valid;
   logic [31:0]      s2_seed;
   logic [31:0]      s2_x_half;
   logic [TAG_W-1:0] s2_tag;
   fp_special_t      s2_special;

   // A stage may load when it is empty or its contents leave this cycle.
   assign adv2     = !s2_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

`ifdef FISR_SPECIAL_CASE_EN
   fp_class_t in_cls, s1_cls;
   logic      in_sign, s1_sign;

   fisr_classify u_classify (
      .x    (in_data),
      .cls  (in_cls),
      .sign (in_sign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_cls  <= NORM;
         s1_sign <= 1'b0;
      end else if (adv1 && in_valid) begin
         s1_cls  <= in_cls;
         s1_sign <= in_sign;
      end
   end

   assign s1_special = special_of(s1_cls, s1_sign);
`else
   assign s1_special = '0;
`endif

   // NOTE: data registers are cleared by reset as well, so outputs read zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_tag   <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_x   <= in_data;
            s1_tag <= in_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         s2_seed    <= '0;
         s2_x_half  <= '0;
         s2_tag     <= '0;
         s2_special <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_seed    <= MAGIC - {1'b0, s1_x[31:1]};
            s2_x_half  <= fp_half(s1_x);
            s2_tag     <= s1_tag;
            s2_special <= s1_special;
         end
      end
   end

   assign out_valid       = s2_valid;
   assign out_seed        = s2_seed;
   assign out_x_half      = s2_x_half;
   assign out_tag         = s2_tag;
   assign out_special     = s2_special.hit;
   assign out_special_val = s2_special.val;

endmodule

// File: tb/tb_fisr_seed_gen.sv
// Directed bench for fisr_seed_gen: vectors, stall/backpressure, reset flush, streaming.
module tb_fisr_seed_gen;

   localparam int TAG_W = 4;

`ifdef FISR_SPECIAL_CASE_EN
   localparam bit SPECIAL_ON = 1'b1;
`else
   localparam bit SPECIAL_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_seed;
   logic [31:0]      out_x_half;
   logic [TAG_W-1:0] out_tag;
   logic             out_special;
   logic [31:0]      out_special_val;

   always #5 clk = ~clk;

   fisr_seed_gen #(.MAGIC(32'h5F3759DF), .TAG_W(TAG_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_tag          (in_tag),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_seed        (out_seed),
      .out_x_half      (out_x_half),
      .out_tag         (out_tag),
      .out_special     (out_special),
      .out_special_val (out_special_val)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] x;
      logic [31:0] seed;
      logic [31:0] half;
      logic [31:0] sval;
      logic        sp;
   } vec_t;

   typedef struct {
      logic [31:0] seed;
      logic [31:0] half;
      logic [31:0] tag;
   } exp_t;

   function automatic logic [31:0] model_half(input logic [31:0] x);
      int e;
      e = int'(x[30:23]);
      if (e == 255) return x;
      if (e < 2) return x & 32'h8000_0000;
      return x - 32'h0080_0000;
   endfunction

   function automatic exp_t model(input logic [31:0] x, input logic [TAG_W-1:0] t);
      exp_t r;
      r.seed = 32'h5F3759DF - (x >> 1);
      r.half = model_half(x);
      r.tag  = {28'h0, t};
      return r;
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // One operand through an empty pipe with out_ready high: visible exactly two edges later.
   task automatic single(input vec_t v, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_data  = v.x;
      in_tag   = t;
      #1;
      check("single_in_ready", {31'h0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      #1;
      check("single_lat1_valid", {31'h0, out_valid}, 32'd0);
      step();
      check("single_valid", {31'h0, out_valid}, 32'd1);
      check($sformatf("seed_%08h", v.x), out_seed, v.seed);
      check($sformatf("half_%08h", v.x), out_x_half, v.half);
      check("single_tag", {28'h0, out_tag}, {28'h0, t});
      check($sformatf("sp_%08h", v.x), {31'h0, out_special}, {31'h0, SPECIAL_ON & v.sp});
      check($sformatf("sval_%08h", v.x), out_special_val, SPECIAL_ON ? v.sval : 32'h0);
      step();
      check("single_drained", {31'h0, out_valid}, 32'd0);
   endtask

   vec_t vecs [10];
   exp_t q [$];

   initial begin
      vecs = '{
         '{32'h40800000, 32'h3EF759DF, 32'h40000000, 32'h00000000, 1'b0},
         '{32'h3F800000, 32'h3F7759DF, 32'h3F000000, 32'h00000000, 1'b0},
         '{32'h00000000, 32'h5F3759DF, 32'h00000000, 32'h7F800000, 1'b1},
         '{32'hBF800000, 32'hFF7759DF, 32'hBF000000, 32'h7FC00000, 1'b1},
         '{32'h7F800000, 32'h1F7759DF, 32'h7F800000, 32'h00000000, 1'b1},
         '{32'h00800000, 32'h5EF759DF, 32'h00000000, 32'h00000000, 1'b0},
         '{32'h80800000, 32'h1EF759DF, 32'h80000000, 32'h7FC00000, 1'b1},
         '{32'h01000000, 32'h5EB759DF, 32'h00800000, 32'h00000000, 1'b0},
         '{32'hFFFFFFFF, 32'hDF3759E0, 32'hFFFFFFFF, 32'h7FC00000, 1'b1},
         '{32'h00000001, 32'h5F3759DF, 32'h00000000, 32'h7F800000, 1'b1}
      };

      do_reset();
      #1;
      check("rst_out_valid", {31'h0, out_valid}, 32'd0);
      check("rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("rst_seed", out_seed, 32'h0);
      check("rst_half", out_x_half, 32'h0);
      check("rst_tag", {28'h0, out_tag}, 32'h0);

      for (int i = 0; i < 10; i++) single(vecs[i], TAG_W'(i));

      // Stall: consumer blocked for five cycles while three operands are offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h40800000;
      in_tag    = 4'd1;
      #1;
      check("stall_rdy0", {31'h0, in_ready}, 32'd1);
      step();
      in_data = 32'h3F800000;
      in_tag  = 4'd2;
      #1;
      check("stall_rdy1", {31'h0, in_ready}, 32'd1);
      step();
      in_data = 32'h01000000;
      in_tag  = 4'd3;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_in_ready", {31'h0, in_ready}, 32'd0);
         check("stall_valid", {31'h0, out_valid}, 32'd1);
         check("stall_tag", {28'h0, out_tag}, 32'd1);
         check("stall_seed", out_seed, 32'h3EF759DF);
         check("stall_half", out_x_half, 32'h40000000);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", {31'h0, in_ready}, 32'd1);
      check("drain1_tag", {28'h0, out_tag}, 32'd1);
      check("drain1_seed", out_seed, 32'h3EF759DF);
      step();
      in_valid = 1'b0;
      #1;
      check("drain2_valid", {31'h0, out_valid}, 32'd1);
      check("drain2_tag", {28'h0, out_tag}, 32'd2);
      check("drain2_seed", out_seed, 32'h3F7759DF);
      step();
      check("drain3_valid", {31'h0, out_valid}, 32'd1);
      check("drain3_tag", {28'h0, out_tag}, 32'd3);
      check("drain3_seed", out_seed, 32'h5EB759DF);
      check("drain3_half", out_x_half, 32'h00800000);
      step();
      check("drain_empty", {31'h0, out_valid}, 32'd0);

      // Reset with both stages occupied flushes everything.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h40800000;
      in_tag    = 4'd7;
      step();
      in_tag = 4'd8;
      step();
      in_valid = 1'b0;
      check("full_before_rst", {31'h0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("flush_valid", {31'h0, out_valid}, 32'd0);
      check("flush_in_ready", {31'h0, in_ready}, 32'd1);
      check("flush_seed", out_seed, 32'h0);
      check("flush_half", out_x_half, 32'h0);
      check("flush_tag", {28'h0, out_tag}, 32'h0);
      step();
      check("flush_no_s1", {31'h0, out_valid}, 32'd0);

      // Sixteen back-to-back operands; results on sixteen consecutive cycles.
      for (int c = 0; c < 18; c++) begin
         in_valid = (c < 16);
         in_data  = 32'h3F800000 + (32'(c) << 23);
         in_tag   = TAG_W'(c);
         #1;
         if (c >= 2) begin
            exp_t e;
            e = model(32'h3F800000 + (32'(c - 2) << 23), TAG_W'(c - 2));
            check("b2b_valid", {31'h0, out_valid}, 32'd1);
            check("b2b_tag", {28'h0, out_tag}, e.tag);
            check("b2b_seed", out_seed, e.seed);
            check("b2b_half", out_x_half, e.half);
         end
         step();
      end
      in_valid = 1'b0;
      #1;
      check("b2b_empty", {31'h0, out_valid}, 32'd0);

      // Random valid/ready gaps against the reference model.
      begin
         int sent;
         int got;
         sent = 0;
         got  = 0;
         q.delete();
         for (int cyc = 0; cyc < 400 && !(sent == 20 && q.size() == 0); cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_tag    = TAG_W'(sent);
            #1;
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("rnd_spurious_valid", {31'h0, out_valid}, 32'd0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("rnd_seed", out_seed, e.seed);
                  check("rnd_half", out_x_half, e.half);
                  check("rnd_tag", {28'h0, out_tag}, e.tag);
                  got++;
               end
            end
            if (in_valid && in_ready) begin
               q.push_back(model(in_data, in_tag));
               sent++;
            end
            step();
         end
         in_valid = 1'b0;
         check("rnd_count", 32'(got), 32'd20);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
